// File: rtl/fetch_pc_pkg.sv
// Shared definitions for the fetch stage and the instruction memory it addresses.
package fetch_pc_pkg;

    localparam int unsigned DEFAULT_ADDR_W = 10;

    typedef logic [DEFAULT_ADDR_W-1:0] addr_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        HALT
    } state_t;

endpackage

// File: rtl/jump_target_lut.sv
// Programmable jump-target table: reset-cleared registers, one write port, one async read port.
module jump_target_lut #(
    parameter int unsigned ADDR_W    = 10,
    parameter int unsigned LUT_DEPTH = 8,
    parameter int unsigned IDX_W     = $clog2(LUT_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [IDX_W-1:0]  waddr,
    input  logic [ADDR_W-1:0] wdata,
    input  logic [IDX_W-1:0]  raddr,
    output logic [ADDR_W-1:0] rdata
);

    logic [ADDR_W-1:0] mem [LUT_DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            mem <= '{default: '0};
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read sees the pre-write contents, so a same-cycle jump uses the old target.
    assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_pc.sv
// Program counter and next-fetch-address selection with IDLE/RUN/HALT control.
module fetch_pc
    import fetch_pc_pkg::*;
#(
    parameter int unsigned ADDR_W    = DEFAULT_ADDR_W,
    parameter int unsigned OFFSET_W  = 6,
    parameter int unsigned LUT_DEPTH = 8,
    localparam int unsigned IDX_W    = $clog2(LUT_DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic                stall,
    input  logic                branch_en,
    input  logic [OFFSET_W-1:0] branch_off,
    input  logic                jump_en,
    input  logic [IDX_W-1:0]    jump_idx,
    input  logic                lut_we,
    input  logic [IDX_W-1:0]    lut_waddr,
    input  logic [ADDR_W-1:0]   lut_wdata,
    input  logic                halt_req,
    output logic [ADDR_W-1:0]   pc,
    output logic                pc_valid,
    output logic [ADDR_W-1:0]   instr_pc,
    output logic                instr_valid,
    output logic                halted,
    output logic                wrapped
);

    state_t            state, state_next;
    logic [ADDR_W-1:0] pc_next;
    logic [ADDR_W-1:0] jump_target;
    logic [ADDR_W-1:0] off_ext;
    logic              wrap_next;

    jump_target_lut #(
        .ADDR_W    (ADDR_W),
        .LUT_DEPTH (LUT_DEPTH),
        .IDX_W     (IDX_W)
    ) u_lut (
        .clk   (clk),
        .rst   (rst),
        .we    (lut_we),
        .waddr (lut_waddr),
        .wdata (lut_wdata),
        .raddr (jump_idx),
        .rdata (jump_target)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start)    state_next = RUN;
            RUN:     if (halt_req) state_next = HALT;
            HALT:    state_next = HALT;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        pc_valid = (state == RUN);
        halted   = (state == HALT);
    end

    assign off_ext = {{(ADDR_W-OFFSET_W){branch_off[OFFSET_W-1]}}, branch_off};

    // Only the plain increment flags a wrap; branches wrap silently.
    always_comb begin
        pc_next   = pc;
        wrap_next = 1'b0;
        if (state == RUN && !halt_req && !stall) begin
            if (jump_en) begin
                pc_next = jump_target;
            end else if (branch_en) begin
                pc_next = pc + off_ext;
            end else begin
                pc_next   = pc + ADDR_W'(1);
                wrap_next = (pc == '1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc          <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            wrapped     <= 1'b0;
        end else begin
            pc          <= pc_next;
            instr_pc    <= pc;
            instr_valid <= pc_valid;
            wrapped     <= wrap_next;
        end
    end

endmodule

// File: tb/tb_fetch_pc.sv
// Self-checking bench for fetch_pc: directed vector table plus randomized run against a reference model.
module tb_fetch_pc;

    logic       clk = 1'b0;
    logic       rst;
    logic       start, stall, branch_en, jump_en, lut_we, halt_req;
    logic [5:0] branch_off;
    logic [2:0] jump_idx, lut_waddr;
    logic [9:0] lut_wdata;
    logic [9:0] pc, instr_pc;
    logic       pc_valid, instr_valid, halted, wrapped;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    fetch_pc #(
        .ADDR_W    (10),
        .OFFSET_W  (6),
        .LUT_DEPTH (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .stall       (stall),
        .branch_en   (branch_en),
        .branch_off  (branch_off),
        .jump_en     (jump_en),
        .jump_idx    (jump_idx),
        .lut_we      (lut_we),
        .lut_waddr   (lut_waddr),
        .lut_wdata   (lut_wdata),
        .halt_req    (halt_req),
        .pc          (pc),
        .pc_valid    (pc_valid),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .halted      (halted),
        .wrapped     (wrapped)
    );

    typedef struct {
        int rstn, start, stall, halt, jmp, idx, br, off, we, wa, wd;
        int e_pc, e_v, e_ipc, e_iv, e_h, e_w;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    task automatic drive(input int rstn, input int st, input int sl, input int hl,
                         input int jm, input int ix, input int bb, input int of,
                         input int w, input int wa, input int wd);
        rst        = 1'(rstn);
        start      = 1'(st);
        stall      = 1'(sl);
        halt_req   = 1'(hl);
        jump_en    = 1'(jm);
        jump_idx   = 3'(ix);
        branch_en  = 1'(bb);
        branch_off = 6'(of);
        lut_we     = 1'(w);
        lut_waddr  = 3'(wa);
        lut_wdata  = 10'(wd);
    endtask

    task automatic check_outputs(input string tag, input int e_pc, input int e_v,
                                 input int e_ipc, input int e_iv, input int e_h, input int e_w);
        check({tag, ".pc"},          int'(pc),          e_pc);
        check({tag, ".pc_valid"},    int'(pc_valid),    e_v);
        check({tag, ".instr_pc"},    int'(instr_pc),    e_ipc);
        check({tag, ".instr_valid"}, int'(instr_valid), e_iv);
        check({tag, ".halted"},      int'(halted),      e_h);
        check({tag, ".wrapped"},     int'(wrapped),     e_w);
    endtask

    // Reference model: plain integers, updated once per rising edge.
    bit m_run, m_halt, m_iv, m_wrap;
    int m_pc, m_ipc;
    int m_lut [8];

    task automatic model_step(input int rstn, input int st, input int sl, input int hl,
                              input int jm, input int ix, input int bb, input int of,
                              input int w, input int wa, input int wd);
        int target;
        int soff;
        if (rstn == 0) begin
            m_run = 0; m_halt = 0; m_iv = 0; m_wrap = 0; m_pc = 0; m_ipc = 0;
            foreach (m_lut[i]) m_lut[i] = 0;
        end else begin
            target = m_lut[ix];
            soff   = (of >= 32) ? of - 64 : of;
            m_ipc  = m_pc;
            m_iv   = m_run;
            m_wrap = 0;
            if (w != 0) m_lut[wa] = wd;
            if (m_run) begin
                if (hl != 0) begin
                    m_run = 0; m_halt = 1;
                end else if (sl != 0) begin
                end else if (jm != 0) begin
                    m_pc = target;
                end else if (bb != 0) begin
                    m_pc = ((m_pc + soff) % 1024 + 1024) % 1024;
                end else begin
                    m_wrap = (m_pc == 1023);
                    m_pc   = (m_pc + 1) % 1024;
                end
            end else if (!m_halt && st != 0) begin
                m_run = 1;
            end
        end
    endtask

    vec_t vecs [$];

    initial begin
        // rstn start stall halt jmp idx br off we wa wd | pc v ipc iv h w
        vecs.push_back('{0,0,0,0,0,0,0,0, 0,0,0,      0,0,0,0,0,0});    // reset
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      0,0,0,0,0,0});    // idle, no start
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,      0,1,0,0,0,0});    // start
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      1,1,0,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      2,1,1,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      3,1,2,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      4,1,3,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      5,1,4,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,1,61,0,0,0,      2,1,5,1,0,0});    // pc5, off -3
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      3,1,2,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,1,62,0,0,0,      1,1,3,1,0,0});    // off -2
        vecs.push_back('{1,0,0,0,0,0,1,60,0,0,0,      1021,1,1,1,0,0}); // pc1, off -4
        vecs.push_back('{1,0,0,0,0,0,0,0, 1,3,512,    1022,1,1021,1,0,0});
        vecs.push_back('{1,0,0,0,1,3,0,0, 0,0,0,      512,1,1022,1,0,0}); // jump lut[3]
        vecs.push_back('{1,0,0,0,1,3,1,5, 0,0,0,      512,1,512,1,0,0});  // jump beats branch
        vecs.push_back('{1,0,0,0,1,3,0,0, 1,3,273,    512,1,512,1,0,0});  // old value used
        vecs.push_back('{1,0,0,0,1,3,0,0, 0,0,0,      273,1,512,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 1,1,7,      274,1,273,1,0,0});
        vecs.push_back('{1,0,0,0,1,1,0,0, 0,0,0,      7,1,274,1,0,0});
        vecs.push_back('{1,0,1,0,0,0,0,0, 0,0,0,      7,1,7,1,0,0});      // stall x3
        vecs.push_back('{1,0,1,0,1,3,1,3, 0,0,0,      7,1,7,1,0,0});
        vecs.push_back('{1,0,1,0,0,0,0,0, 0,0,0,      7,1,7,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      8,1,7,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 1,2,1022,   9,1,8,1,0,0});
        vecs.push_back('{1,0,0,0,1,2,0,0, 0,0,0,      1022,1,9,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      1023,1,1022,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      0,1,1023,1,0,1});   // wrap
        vecs.push_back('{1,0,0,0,0,0,0,0, 1,4,9,      1,1,0,1,0,0});
        vecs.push_back('{1,0,0,0,1,4,0,0, 0,0,0,      9,1,1,1,0,0});
        vecs.push_back('{1,0,0,1,0,0,0,0, 0,0,0,      9,0,9,1,1,0});      // halt
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,      9,0,9,0,1,0});      // start ignored
        vecs.push_back('{1,0,0,0,1,4,0,0, 0,0,0,      9,0,9,0,1,0});
        vecs.push_back('{0,1,0,0,1,4,0,0, 0,0,0,      0,0,0,0,0,0});      // reset
        vecs.push_back('{1,1,0,0,0,0,0,0, 0,0,0,      0,1,0,0,0,0});
        vecs.push_back('{1,0,0,0,1,3,0,0, 0,0,0,      0,1,0,1,0,0});      // table cleared
        vecs.push_back('{1,0,0,0,1,4,0,0, 0,0,0,      0,1,0,1,0,0});
        vecs.push_back('{1,0,0,0,0,0,0,0, 0,0,0,      1,1,0,1,0,0});

        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        foreach (vecs[i]) begin
            vec_t v;
            v = vecs[i];
            drive(v.rstn, v.start, v.stall, v.halt, v.jmp, v.idx, v.br, v.off, v.we, v.wa, v.wd);
            @(posedge clk);
            #1;
            check_outputs($sformatf("vec%0d", i), v.e_pc, v.e_v, v.e_ipc, v.e_iv, v.e_h, v.e_w);
        end

        // Randomized run; model starts from reset alongside the DUT.
        model_step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;
        for (int c = 0; c < 600; c++) begin
            int r_rstn, r_st, r_sl, r_hl, r_jm, r_ix, r_bb, r_of, r_w, r_wa, r_wd;
            r_rstn = ($urandom_range(0, 149) == 0) ? 0 : 1;
            r_st   = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r_sl   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_hl   = ($urandom_range(0, 79) == 0) ? 1 : 0;
            r_jm   = ($urandom_range(0, 5) == 0) ? 1 : 0;
            r_ix   = int'($urandom_range(0, 7));
            r_bb   = ($urandom_range(0, 4) == 0) ? 1 : 0;
            r_of   = int'($urandom_range(0, 63));
            r_w    = ($urandom_range(0, 3) == 0) ? 1 : 0;
            r_wa   = int'($urandom_range(0, 7));
            r_wd   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1018, 1023))
                                                 : int'($urandom_range(0, 1023));
            drive(r_rstn, r_st, r_sl, r_hl, r_jm, r_ix, r_bb, r_of, r_w, r_wa, r_wd);
            model_step(r_rstn, r_st, r_sl, r_hl, r_jm, r_ix, r_bb, r_of, r_w, r_wa, r_wd);
            @(posedge clk);
            #1;
            check_outputs($sformatf("rnd%0d", c), m_pc, int'(m_run), m_ipc, int'(m_iv),
                          int'(m_halt), int'(m_wrap));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
